// File: rtl/mmio_pkg.sv
// Shared bus command encoding and default I/O register addresses for the MMIO bridge.
package mmio_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10,
    MRSVD  = 2'b11
  } mem_cmd_e;

  localparam logic [8:0] LED_BASE  = 9'h100;
  localparam logic [8:0] SW_BASE   = 9'h140;
  localparam logic [8:0] EDGE_BASE = 9'h141;

endpackage

// File: rtl/sw_debounce.sv
// Switch synchroniser plus per-bit debounce; sw_db lags a stable sw_in change by 2+DEBOUNCE_CYCLES edges.
// rise is a same-cycle pulse that coincides with the edge at which sw_db goes 0->1.
module sw_debounce #(
  parameter int N_SW            = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] sw_in,
  output logic [N_SW-1:0] sw_db,
  output logic [N_SW-1:0] rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N_SW-1:0]  sync1;
  logic [N_SW-1:0]  sw_sync;
  logic [N_SW-1:0]  flip;
  logic [CNT_W-1:0] cnt [N_SW];

  always_comb begin
    flip = '0;
    for (int i = 0; i < N_SW; i++) begin
      flip[i] = (sw_sync[i] != sw_db[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign rise = flip & ~sw_db;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= '0;
      sw_sync <= '0;
      sw_db   <= '0;
      for (int i = 0; i < N_SW; i++) cnt[i] <= '0;
    end else begin
      sync1   <= sw_in;
      sw_sync <= sync1;
      sw_db   <= sw_db ^ flip;
      // Any agreement with sw_db, or an accepted change, restarts the stability count.
      for (int i = 0; i < N_SW; i++) begin
        if ((sw_sync[i] == sw_db[i]) || flip[i]) cnt[i] <= '0;
        else                                     cnt[i] <= cnt[i] + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/mmio_io_bridge.sv
// MMIO bridge for LEDs, debounced switches and a read-clear switch rise register.
// Reads return registered data with a 1-cycle valid strobe; no backpressure, every command completes.
module mmio_io_bridge #(
  parameter int                ADDR_W          = 9,
  parameter int                DATA_W          = 16,
  parameter int                N_SW            = 8,
  parameter int                N_LED           = 8,
  parameter logic [ADDR_W-1:0] LED_BASE        = mmio_pkg::LED_BASE,
  parameter logic [ADDR_W-1:0] SW_BASE         = mmio_pkg::SW_BASE,
  parameter logic [ADDR_W-1:0] EDGE_BASE       = mmio_pkg::EDGE_BASE,
  parameter int                DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              io_sel,
  input  logic [N_SW-1:0]   sw_in,
  output logic [N_LED-1:0]  led_out
);

  import mmio_pkg::*;

  logic [N_SW-1:0]   sw_db;
  logic [N_SW-1:0]   rise;
  logic [N_SW-1:0]   edge_q;
  logic [N_LED-1:0]  led_q;
  logic              sel_led, sel_sw, sel_edge;
  logic              rd_io, rd_edge, wr_led;
  logic [DATA_W-1:0] rd_mux;

  sw_debounce #(
    .N_SW            (N_SW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk   (clk),
    .reset (reset),
    .sw_in (sw_in),
    .sw_db (sw_db),
    .rise  (rise)
  );

  assign sel_led  = (mem_addr == LED_BASE);
  assign sel_sw   = (mem_addr == SW_BASE);
  assign sel_edge = (mem_addr == EDGE_BASE);
  assign io_sel   = sel_led | sel_sw | sel_edge;

  assign rd_io   = (mem_cmd == MREAD) && io_sel;
  assign rd_edge = (mem_cmd == MREAD) && sel_edge;
  assign wr_led  = (mem_cmd == MWRITE) && sel_led;

  always_comb begin
    rd_mux = '0;
    if (sel_led)       rd_mux[N_LED-1:0] = led_q;
    else if (sel_sw)   rd_mux[N_SW-1:0]  = sw_db;
    else if (sel_edge) rd_mux[N_SW-1:0]  = edge_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q      <= '0;
      edge_q     <= '0;
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      if (wr_led) led_q <= write_data[N_LED-1:0];
      // A rise landing on the clearing read's edge survives the clear.
      edge_q <= (rd_edge ? '0 : edge_q) | rise;
      if (rd_io) begin
        read_data  <= rd_mux;
        read_valid <= 1'b1;
      end else begin
        read_valid <= 1'b0;
      end
    end
  end

  assign led_out = led_q;

endmodule

// File: tb/tb_mmio_io_bridge.sv
// Directed and random stimulus for mmio_io_bridge against a window-based behavioural model.
module tb_mmio_io_bridge;
  import mmio_pkg::*;

  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        read_valid;
  logic        io_sel;
  logic [7:0]  sw_in;
  logic [7:0]  led_out;

  int total = 0;
  int bad   = 0;

  // model state: pipeline of switch samples, accepted switch value, registers
  logic [7:0]  m_s1, m_s2, m_db, m_edge, m_led;
  logic [15:0] m_rd;
  logic        m_rv;
  logic [7:0]  hist[$];

  mmio_io_bridge #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .read_valid (read_valid),
    .io_sel     (io_sel),
    .sw_in      (sw_in),
    .led_out    (led_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_io(input logic [8:0] a);
    return (a == LED_BASE) || (a == SW_BASE) || (a == EDGE_BASE);
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_edge = '0; m_led = '0;
    m_rd = '0; m_rv = 1'b0;
    hist.delete();
  endtask

  // One clock edge: check io_sel before it, advance the model, check outputs after it.
  task automatic tick();
    logic [1:0]  c;
    logic [8:0]  a;
    logic [15:0] wd;
    logic [7:0]  sw, flips, rise, new_edge;
    logic        all_diff;
    #1;
    check("io_sel", io_sel, is_io(mem_addr));
    c = mem_cmd; a = mem_addr; wd = write_data; sw = sw_in;
    @(posedge clk);
    hist.push_back(m_s2);
    if (hist.size() > DC) void'(hist.pop_front());
    flips = '0;
    if (hist.size() == DC) begin
      for (int i = 0; i < 8; i++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DC; k++) if (hist[k][i] == m_db[i]) all_diff = 1'b0;
        flips[i] = all_diff;
      end
    end
    rise = flips & ~m_db;
    if (c == MREAD && is_io(a)) begin
      m_rv = 1'b1;
      if (a == LED_BASE)     m_rd = {8'h00, m_led};
      else if (a == SW_BASE) m_rd = {8'h00, m_db};
      else                   m_rd = {8'h00, m_edge};
    end else begin
      m_rv = 1'b0;
    end
    new_edge = ((c == MREAD && a == EDGE_BASE) ? 8'h00 : m_edge) | rise;
    if (c == MWRITE && a == LED_BASE) m_led = wd[7:0];
    m_db   = m_db ^ flips;
    m_edge = new_edge;
    m_s2   = m_s1;
    m_s1   = sw;
    #1;
    check("read_valid", read_valid, m_rv);
    check("read_data", read_data, m_rd);
    check("led_out", led_out, m_led);
  endtask

  task automatic do_cmd(input logic [1:0] c, input logic [8:0] a, input logic [15:0] wd);
    mem_cmd = c; mem_addr = a; write_data = wd;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cmd(MNONE, 9'h000, 16'h0000);
  endtask

  initial begin
    reset = 1'b1; mem_cmd = MNONE; mem_addr = '0; write_data = '0; sw_in = '0;
    model_reset();
    #12;
    check("rst_led", led_out, 8'h00);
    check("rst_rv", read_valid, 1'b0);
    check("rst_rd", read_data, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // LED write then read-back
    do_cmd(MWRITE, LED_BASE, 16'h00A5);
    check("led_after_wr", led_out, 8'hA5);
    do_cmd(MREAD, LED_BASE, 16'h0000);
    check("led_rd_valid", read_valid, 1'b1);
    check("led_rd_data", read_data, 16'h00A5);
    idle(1);
    check("led_rd_one_cycle", read_valid, 1'b0);

    // debounce latency: read sampled at edge 5 sees old value, edge 7 sees new
    sw_in = 8'h01;
    for (int n = 1; n <= 8; n++) begin
      do_cmd(MREAD, SW_BASE, 16'h0000);
      check("sw_rd_b2b_valid", read_valid, 1'b1);
      if (n == 5) check("sw_rd_edge5", read_data, 16'h0000);
      if (n == 7) check("sw_rd_edge7", read_data, 16'h0001);
    end
    do_cmd(MREAD, EDGE_BASE, 16'h0000);
    check("edge_bit0", read_data, 16'h0001);

    // release, then a 2-cycle glitch must be filtered
    sw_in = 8'h00;
    idle(8);
    sw_in = 8'h01;
    idle(2);
    sw_in = 8'h00;
    for (int n = 0; n < 8; n++) do_cmd(MREAD, SW_BASE, 16'h0000);
    check("glitch_sw", read_data, 16'h0000);
    do_cmd(MREAD, EDGE_BASE, 16'h0000);
    check("glitch_edge", read_data, 16'h0000);

    // edge register read-clear, and a rise coincident with the clear
    sw_in = 8'h03;
    idle(8);
    do_cmd(MREAD, EDGE_BASE, 16'h0000);
    check("edge_rd1", read_data, 16'h0003);
    do_cmd(MREAD, EDGE_BASE, 16'h0000);
    check("edge_rd2", read_data, 16'h0000);
    sw_in = 8'h07;
    idle(5);
    do_cmd(MREAD, EDGE_BASE, 16'h0000);
    check("edge_coincident_rd", read_data, 16'h0000);
    do_cmd(MREAD, EDGE_BASE, 16'h0000);
    check("edge_coincident_kept", read_data, 16'h0004);

    // writes to read-only and reads of non-I/O space have no effect
    do_cmd(MWRITE, SW_BASE, 16'hFFFF);
    check("wr_sw_led", led_out, 8'hA5);
    mem_cmd = MREAD; mem_addr = 9'h050; #1;
    check("io_sel_050", io_sel, 1'b0);
    tick();
    check("rd_050_valid", read_valid, 1'b0);
    do_cmd(MREAD, SW_BASE, 16'h0000);
    check("sw_after_wr", read_data, 16'h0007);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [8:0] a;
      logic [1:0] c;
      case ($urandom_range(0, 3))
        0: a = LED_BASE;
        1: a = SW_BASE;
        2: a = EDGE_BASE;
        default: a = 9'($urandom_range(0, 511));
      endcase
      c = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) sw_in = 8'($urandom);
      do_cmd(c, a, 16'($urandom));
    end

    // asynchronous reset mid-stream with a read in flight
    do_cmd(MWRITE, LED_BASE, 16'h00A5);
    sw_in = 8'h00;
    idle(8);
    sw_in = 8'hFF;
    idle(8);
    do_cmd(MREAD, LED_BASE, 16'h0000);
    check("inflight_valid", read_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("arst_led", led_out, 8'h00);
    check("arst_rv", read_valid, 1'b0);
    check("arst_rd", read_data, 16'h0000);
    model_reset();
    mem_cmd = MREAD; mem_addr = EDGE_BASE;
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("edge_after_rst", read_data, 16'h0000);
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_io_bridge.md
Name: mmio_io_bridge

Overview:
- Parametrised memory-mapped I/O bridge that sits between the CPU memory interface (mem_cmd / mem_addr / write_data) and board I/O.
- Generalises the fixed switch/LED decode of the current top level:
  - parametrised widths and base addresses
  - synchronised and debounced switch inputs
  - a readable LED register
  - a sticky switch-rising-edge register that is cleared when read
- Reads return registered data with a valid strobe. io_sel tells RAM to ignore I/O addresses.

Parameters:
ADDR_W, 9, memory address width
DATA_W, 16, data bus width
N_SW, 8, switch input count (N_SW <= DATA_W)
N_LED, 8, LED output count (N_LED <= DATA_W)
LED_BASE, 9'h100, LED register address (read/write)
SW_BASE, 9'h140, debounced switch value address (read-only)
EDGE_BASE, 9'h141, sticky rising-edge register address (read clears)
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a switch change (>= 1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
mem_cmd  input  2  bus command: 2'b00 MNONE, 2'b01 MREAD, 2'b10 MWRITE, 2'b11 treated as MNONE
mem_addr  input  ADDR_W  bus address
write_data  input  DATA_W  bus write data
read_data  output  DATA_W  registered read data
read_valid  output  1  one-cycle strobe: read_data holds an I/O read result
io_sel  output  1  combinational; 1 when mem_addr equals LED_BASE, SW_BASE or EDGE_BASE (RAM must not respond)
sw_in  input  N_SW  raw asynchronous switch inputs
led_out  output  N_LED  LED register contents

Behaviour:
- Clock and reset:
  - One clock (clk).
  - reset is asynchronous and active-high.
  - While reset is high: led_out=0, read_data=0, read_valid=0, both sync stages=0, debounced value sw_db=0, edge register=0, all debounce counters=0.
  - Asserting reset mid-operation clears everything immediately. No pending read survives.
- Switch input path:
  - Each switch bit passes through a 2-flop synchroniser to give sw_sync.
- Debounce (per bit i):
  - If sw_sync[i]==sw_db[i]: counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and the bit still differs: sw_db[i] flips at that edge and the counter clears.
  - Net latency from a stable sw_in change to sw_db is 2+DEBOUNCE_CYCLES clock edges.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles never reaches sw_db.
  - DEBOUNCE_CYCLES=1 means sw_db follows sw_sync with one cycle delay.
- Edge register:
  - Bit i is set when sw_db[i] goes 0->1.
  - Bits stay set (sticky) until a read of EDGE_BASE.
- Write (mem_cmd==MWRITE, sampled at edge):
  - Address == LED_BASE: led_out <= write_data[N_LED-1:0] at that edge.
  - Any other address (including SW_BASE and EDGE_BASE): no effect.
- Read (mem_cmd==MREAD with io_sel=1, sampled at edge N):
  - After edge N, read_valid=1 and read_data holds:
    - LED_BASE: led_out, zero-extended
    - SW_BASE: sw_db, zero-extended
    - EDGE_BASE: edge register contents, zero-extended; the edge register clears at edge N
  - Read latency is exactly 1 cycle.
  - read_valid is high for exactly one cycle per read command. Back-to-back reads give back-to-back strobes.
- Non-I/O read: read_valid=0 and read_data holds its previous value.
- Read of LED_BASE in the cycle after a write returns the newly written value.
- Simultaneous events: a rising edge detected at the same edge as an EDGE_BASE read-clear leaves that bit set. The read returns the pre-edge value.
- Reads of SW_BASE return sw_db, never raw or synced values.

Decomposition:
- Shared package mmio_pkg holds:
  - mem_cmd constants MNONE/MREAD/MWRITE
  - default base addresses LED_BASE/SW_BASE/EDGE_BASE
- One sub-module, sw_debounce (parameters N_SW, DEBOUNCE_CYCLES), containing:
  - synchroniser
  - per-bit counters
  - outputs sw_db and rise pulse vector
- The top instantiates sw_debounce and contains the address decode, LED register, edge register and read mux.

Test Plan:
- Reset then MWRITE LED_BASE write_data=16'h00A5, then MREAD LED_BASE -> led_out=8'hA5 after the write edge; read_valid high for 1 cycle with read_data=16'h00A5; io_sel=1 for both accesses.
- sw_in=8'h01 held, DEBOUNCE_CYCLES=4 -> sw_db changes exactly 6 edges later; MREAD SW_BASE returns 16'h0001 (read at 5 edges returns 16'h0000).
- sw_in bit0 pulsed high for 2 cycles then low -> SW_BASE reads stay 16'h0000 and edge register stays 0.
- sw_in 8'h00->8'h03 debounced, then MREAD EDGE_BASE -> returns 16'h0003; an immediate second read returns 16'h0000; a rise coincident with the clearing read stays set.
- MWRITE SW_BASE 16'hFFFF, and MREAD to 9'h050 -> no state change; io_sel=0 for 9'h050; read_valid stays 0.
- reset asserted mid-stream (led_out=8'hA5, edge bits set, read in flight) -> all outputs 0 immediately, without waiting for clk; the next read of EDGE_BASE returns 16'h0000.
